puf_majority_eval: RTL

//  Sequencer for a bank of N_CHAINS arbiter-PUF delay chains, each C_LENGTH stages long; the chains sit outside this block.
//  Per request: applies one challenge, runs N_EVAL launch/sample evaluations, majority-votes each response bit.

---
 rtl/puf_majority_eval.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/puf_majority_eval.sv
// puf_majority_eval
//   Sequencer for an external bank of arbiter-PUF delay chains. It accepts one
//   challenge, runs N_EVAL launch/sample evaluations, majority-votes each
//   response bit and reports the voted response with a per-bit instability mask.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   chal_valid/ready/data   challenge handshake (chal_ready high only in IDLE)
//   resp_valid/ready        response handshake, resp_* held until taken
//   resp_data       majority-voted response (N_CHAINS bits)
//   resp_unstable   1 = bit was not unanimous across the N_EVAL samples
//   busy            evaluation in progress (acceptance through FINAL)
//   puf_challenge   mux selects to the chains, held from acceptance onward
//   puf_launch      launch level into both chain inputs
//   puf_resp_raw    asynchronous arbiter latch outputs, synchronised here
//
// All outputs are registered.
module puf_majority_eval #(
   parameter int unsigned C_LENGTH      = 8,
   parameter int unsigned N_CHAINS      = 8,
   parameter int unsigned N_EVAL        = 7,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                chal_valid,
   output logic                chal_ready,
   input  logic [C_LENGTH-1:0] chal_data,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [N_CHAINS-1:0] resp_data,
   output logic [N_CHAINS-1:0] resp_unstable,
   output logic                busy,
   output logic [C_LENGTH-1:0] puf_challenge,
   output logic                puf_launch,
   input  logic [N_CHAINS-1:0] puf_resp_raw
);

   // Vote counters and eval counter share a width that holds 0..N_EVAL.
   localparam int unsigned CW = $clog2(N_EVAL + 1);
   localparam int unsigned PW = $clog2(SETTLE_CYCLES);

   localparam logic [CW-1:0] EV_FULL = CW'(N_EVAL);
   localparam logic [CW-1:0] EV_LAST = CW'(N_EVAL - 1);
   localparam logic [CW-1:0] HALF    = CW'(N_EVAL / 2);
   localparam logic [PW-1:0] PH_LAST = PW'(SETTLE_CYCLES - 1);

   if ((N_EVAL % 2) == 0) begin : g_bad_n_eval
      $fatal(1, "puf_majority_eval: N_EVAL must be odd");
   end
   if (SETTLE_CYCLES < 3) begin : g_bad_settle
      $fatal(1, "puf_majority_eval: SETTLE_CYCLES must be >= 3");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_FINAL,
      ST_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       phase_q, phase_d;
   logic [CW-1:0]       eval_q, eval_d;
   logic [CW-1:0]       cnt_q [N_CHAINS];
   logic [CW-1:0]       cnt_d [N_CHAINS];
   logic [N_CHAINS-1:0] sync1_q, sync2_q;

   logic                chal_ready_d, resp_valid_d, busy_d, launch_d;
   logic [N_CHAINS-1:0] resp_data_d, resp_unstable_d;
   logic [C_LENGTH-1:0] challenge_d;

   always_comb begin
      state_d         = state_q;
      phase_d         = phase_q;
      eval_d          = eval_q;
      cnt_d           = cnt_q;
      chal_ready_d    = chal_ready;
      resp_valid_d    = resp_valid;
      resp_data_d     = resp_data;
      resp_unstable_d = resp_unstable;
      busy_d          = busy;
      challenge_d     = puf_challenge;

      case (state_q)
         ST_IDLE: begin
            chal_ready_d = 1'b1;
            if (chal_valid && chal_ready) begin
               challenge_d  = chal_data;
               phase_d      = '0;
               eval_d       = '0;
               for (int unsigned i = 0; i < N_CHAINS; i++) cnt_d[i] = '0;
               chal_ready_d = 1'b0;
               busy_d       = 1'b1;
               state_d      = ST_LOW;
            end
         end
         ST_LOW: begin
            if (phase_q == PH_LAST) begin
               phase_d = '0;
               state_d = ST_HIGH;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         ST_HIGH: begin
            if (phase_q == PH_LAST) begin
               phase_d = '0;
               for (int unsigned i = 0; i < N_CHAINS; i++)
                  cnt_d[i] = cnt_q[i] + CW'(sync2_q[i]);
               eval_d  = (eval_q == EV_FULL) ? eval_q : eval_q + CW'(1);
               state_d = (eval_q == EV_LAST) ? ST_FINAL : ST_LOW;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         ST_FINAL: begin
            for (int unsigned i = 0; i < N_CHAINS; i++) begin
               resp_data_d[i]     = cnt_q[i] > HALF;
               resp_unstable_d[i] = (cnt_q[i] != '0) && (cnt_q[i] != EV_FULL);
            end
            resp_valid_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = ST_DONE;
         end
         ST_DONE: begin
            if (resp_valid && resp_ready) begin
               resp_valid_d = 1'b0;
               chal_ready_d = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Launch is registered from the next state so it is high exactly
      // while the FSM sits in HIGH.
      launch_d = (state_d == ST_HIGH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         phase_q       <= '0;
         eval_q        <= '0;
         for (int unsigned i = 0; i < N_CHAINS; i++) cnt_q[i] <= '0;
         sync1_q       <= '0;
         sync2_q       <= '0;
         chal_ready    <= 1'b0;
         resp_valid    <= 1'b0;
         resp_data     <= '0;
         resp_unstable <= '0;
         busy          <= 1'b0;
         puf_challenge <= '0;
         puf_launch    <= 1'b0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         eval_q        <= eval_d;
         cnt_q         <= cnt_d;
         sync1_q       <= puf_resp_raw;
         sync2_q       <= sync1_q;
         chal_ready    <= chal_ready_d;
         resp_valid    <= resp_valid_d;
         resp_data     <= resp_data_d;
         resp_unstable <= resp_unstable_d;
         busy          <= busy_d;
         puf_challenge <= challenge_d;
         puf_launch    <= launch_d;
      end
   end

endmodule
